// File: rtl/otp_arbiter.sv
// otp_arbiter: shares the single combinational OTP read port between the IFU and the LSU,
// holding the word address for WAIT_CYCLES cycles and returning a registered read word.
module otp_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] otp_pa,
  input  logic [31:0] otp_pdataout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        last_lsu_r;
  logic        own_lsu_r;
  logic        oor_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic        ifu_rvalid_r;
  logic        lsu_rvalid_r;
  logic        ifu_err_r;
  logic        lsu_err_r;

  logic        window_s;
  logic        contend_s;
  logic        pick_lsu_s;
  logic        grant_s;
  logic        gnt_oor_s;
  logic [31:0] gnt_addr_s;
  logic        unused_addr_bits_s;

  // Arbitration: grants only in IDLE or RESP; the round-robin bit breaks ties.
  always_comb begin
    window_s   = 1'b0;
    contend_s  = 1'b0;
    pick_lsu_s = 1'b0;
    grant_s    = 1'b0;
    gnt_addr_s = 32'h0;
    gnt_oor_s  = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_RESP)) begin
      window_s = 1'b1;
    end else begin
      window_s = 1'b0;
    end
    contend_s = ifu_req & lsu_req;
    if (contend_s) begin
      pick_lsu_s = ~last_lsu_r;
    end else begin
      pick_lsu_s = lsu_req;
    end
    grant_s = window_s & (ifu_req | lsu_req);
    if (pick_lsu_s) begin
      gnt_addr_s = lsu_addr;
    end else begin
      gnt_addr_s = ifu_addr;
    end
    gnt_oor_s = (gnt_addr_s[31:2] >= DEPTH_LIM);
    ifu_gnt   = grant_s & ~pick_lsu_s;
    lsu_gnt   = grant_s & pick_lsu_s;
  end

  // Access sequencer: latch on grant, hold the address for WAIT_CYCLES, then present the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      last_lsu_r   <= 1'b0;
      own_lsu_r    <= 1'b0;
      oor_r        <= 1'b0;
      addr_r       <= 32'h0;
      data_r       <= 32'h0;
      ifu_rvalid_r <= 1'b0;
      lsu_rvalid_r <= 1'b0;
      ifu_err_r    <= 1'b0;
      lsu_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_RESP;
            // Out-of-range reads still address the OTP but the returned word is discarded.
            if (oor_r) begin
              data_r <= 32'h0;
            end else begin
              data_r <= otp_pdataout;
            end
            ifu_rvalid_r <= ~own_lsu_r;
            lsu_rvalid_r <= own_lsu_r;
            ifu_err_r    <= ~own_lsu_r & oor_r;
            lsu_err_r    <= own_lsu_r & oor_r;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          ifu_rvalid_r <= 1'b0;
          lsu_rvalid_r <= 1'b0;
          ifu_err_r    <= 1'b0;
          lsu_err_r    <= 1'b0;
          if (grant_s) begin
            state_r <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (grant_s) begin
        addr_r    <= gnt_addr_s;
        own_lsu_r <= pick_lsu_s;
        oor_r     <= gnt_oor_s;
        cnt_r     <= 4'd0;
        if (contend_s) begin
          last_lsu_r <= pick_lsu_s;
        end
      end
    end
  end

  assign ifu_rvalid = ifu_rvalid_r;
  assign lsu_rvalid = lsu_rvalid_r;
  assign ifu_err    = ifu_err_r;
  assign lsu_err    = lsu_err_r;
  assign ifu_rdata  = data_r;
  assign lsu_rdata  = data_r;
  assign otp_pa     = {addr_r[31:2], 2'b00};

  assign unused_addr_bits_s = ^addr_r[1:0];

endmodule

// File: doc/otp_arbiter.md
# otp_arbiter

- Shares the single combinational OTP read port (4 KB, 32-bit words, byte address in, word index = addr[31:2]) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Grants one request at a time and holds the OTP address stable for a programmable number of access cycles. It then returns the registered read word to the winning requester with a one-cycle valid pulse.
- Sits between the core's fetch/load paths and the OTP macro.

## Interface
- WAIT_CYCLES, 2, OTP access time in clock cycles; legal range 1..15.
- DEPTH_WORDS, 1024, number of implemented OTP words; word indices >= DEPTH_WORDS are out of range.
- clk  input  1  core clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ifu_req  input  1  IFU read request; held until ifu_gnt.
- ifu_addr  input  32  IFU byte address; bits [1:0] ignored.
- ifu_gnt  output  1  combinational accept of the IFU request this cycle.
- ifu_rvalid  output  1  one-cycle pulse: ifu_rdata/ifu_err valid.
- ifu_rdata  output  32  IFU read data.
- ifu_err  output  1  out-of-range access flag, qualified by ifu_rvalid.
- lsu_req, lsu_addr, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err: same as the IFU ports, for the LSU.
- otp_pa  output  32  byte address driven to the OTP.
- otp_pdataout  input  32  OTP read data (combinational from otp_pa).

## Operation
- FSM states:
  - IDLE.
  - ACCESS: counter cnt runs 0..WAIT_CYCLES-1.
  - RESP.
- Grant window: the arbiter may grant only in IDLE or RESP.
- Arbitration when exactly one requester is asserted: that requester is granted.
- Arbitration when both are asserted: a round-robin bit last_lsu selects the winner.
  - last_lsu=0 → LSU wins; last_lsu=1 → IFU wins.
  - last_lsu updates only on a contended grant; the value after reset is 0, so LSU wins the first contention.
- On grant:
  - Latch addr into addr_q and the owner into own_q.
  - Compute oor_q = (addr[31:2] >= DEPTH_WORDS).
  - Go to ACCESS with cnt=0.
- ACCESS:
  - otp_pa = {addr_q[31:2], 2'b00}.
  - cnt increments each cycle.
  - When cnt == WAIT_CYCLES-1: register otp_pdataout into data_q (or 32'h0 if oor_q), then go to RESP.
- RESP:
  - Assert <own>_rvalid for exactly one cycle, with <own>_rdata = data_q and <own>_err = oor_q.
  - If either request is pending, grant in the same cycle and go to ACCESS; otherwise go to IDLE.
- The non-owner's rvalid stays 0. The rdata outputs of both ports show data_q; only rvalid qualifies them.
- Out-of-range accesses take the same latency as normal accesses. The OTP is still addressed, but its data is discarded.
- A request dropped before its grant is not an error; the arbiter ignores requests while in ACCESS.
- gnt is never asserted for both ports in the same cycle.

## Timing
- Reset values: every gnt/rvalid/err output is 0; rdata = 0; otp_pa = 0; state = IDLE; cnt = 0; last_lsu = 0.
- Latency: grant in cycle T → rvalid in cycle T+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+1 cycles under continuous requests.
- otp_pa:
  - Changes only on the clock edge after a grant.
  - Stable for the whole ACCESS interval.
  - Holds its last value in IDLE/RESP; it does not return to 0.
- rst_n assertion mid-ACCESS or mid-RESP:
  - Immediately clears state and outputs.
  - The in-flight response is lost and no rvalid is emitted.
  - After release, the first grant is possible in the first cycle with rst_n high.
- Simultaneous response and new grant in RESP:
  - The rvalid for the old owner and the gnt for the new owner are both asserted in that cycle.
  - addr_q is overwritten at the end of that cycle.

## Test plan
- Single IFU read, WAIT_CYCLES=2:
  - Stimulus: ifu_req with addr 0x0000_0008, OTP word 2 = 0xDEAD_BEEF.
  - Required: ifu_gnt in cycle T; otp_pa=0x8 during T+1..T+2; ifu_rvalid at T+3 with rdata 0xDEAD_BEEF, err=0.
- Contention:
  - Stimulus: both requesters held for 4 transactions.
  - Required: grant order LSU, IFU, LSU, IFU; rvalid spacing 3 cycles; never two gnts at once.
- Out of range:
  - Stimulus: lsu_addr = 0x0000_1000 (word 1024).
  - Required: lsu_rvalid at T+3 with rdata 0, lsu_err=1; the IFU port is untouched.
- Back-to-back:
  - Stimulus: ifu_req held continuously, addresses 0x0, 0x4, 0x8.
  - Required: grants coincide with rvalid of the previous access; three rvalids, 3 cycles apart, with the correct words.
- Reset mid-access:
  - Stimulus: rst_n low during ACCESS cnt=1.
  - Required: all outputs 0 asynchronously; no rvalid after release; a fresh request completes normally.
- Parameter sweep:
  - Stimulus: WAIT_CYCLES=1 and WAIT_CYCLES=15.
  - Required: latency 2 and 16 cycles respectively; data correct.
